// File: rtl/pipe_event_monitor.sv
// rtl/pipe_event_monitor.sv - pipeline event counters, stall-run statistics and flush PC trace
//
// Purpose:
//   Passive observer beside the pipelined datapath. It counts cycles, stall
//   cycles, flush cycles, stall episodes, the longest and the current stall
//   run, all saturating. A circular trace records the PC on every flush and
//   can be popped oldest-first.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   en           in   monitor enable (counters, run state and trace push)
//   freeze       in   holds counters and run state; trace keeps capturing
//   clear        in   synchronous clear of counters, run state and trace
//   pc_in        in   PC from the datapath
//   stall_in     in   pipeline stall indication
//   flush_in     in   pipeline flush indication
//   rd_sel       in   counter select (0..5, 6/7 read as zero)
//   rd_data      out  registered selected counter
//   tr_rd_en     in   pop request for the oldest trace entry
//   tr_rd_data   out  popped PC
//   tr_rd_valid  out  one-cycle pulse with tr_rd_data
//   tr_count     out  trace occupancy
//   tr_overflow  out  sticky: an unread entry was overwritten
module pipe_event_monitor #(
  parameter int CNT_W       = 32,
  parameter int PC_W        = 32,
  parameter int TRACE_DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           en,
  input  logic                           freeze,
  input  logic                           clear,
  input  logic [PC_W-1:0]                pc_in,
  input  logic                           stall_in,
  input  logic                           flush_in,
  input  logic [2:0]                     rd_sel,
  output logic [CNT_W-1:0]               rd_data,
  input  logic                           tr_rd_en,
  output logic [PC_W-1:0]                tr_rd_data,
  output logic                           tr_rd_valid,
  output logic [$clog2(TRACE_DEPTH):0]   tr_count,
  output logic                           tr_overflow
);

  localparam int AW = $clog2(TRACE_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0]    PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]    OCC_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]    OCC_FULL = CW'(TRACE_DEPTH);

  // Counter indices
  localparam int C_CYC   = 0;
  localparam int C_STALL = 1;
  localparam int C_FLUSH = 2;
  localparam int C_EPI   = 3;
  localparam int C_MAX   = 4;
  localparam int C_RUN   = 5;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (v == {CNT_W{1'b1}}) ? v : v + CNT_ONE;
  endfunction

  // ------------------------------------------------------------------
  // Counters and stall-run state
  // ------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q [6];
  logic [CNT_W-1:0] cnt_d [6];
  logic             prev_stall_q, prev_stall_d;
  logic [CNT_W-1:0] run_inc;
  logic             count_en;

  assign count_en = en && !freeze && !clear;
  assign run_inc  = sat_inc(cnt_q[C_RUN]);

  always_comb begin
    for (int i = 0; i < 6; i++) cnt_d[i] = cnt_q[i];
    prev_stall_d = prev_stall_q;

    if (clear) begin
      for (int i = 0; i < 6; i++) cnt_d[i] = '0;
      prev_stall_d = 1'b0;
    end else if (count_en) begin
      prev_stall_d = stall_in;
      cnt_d[C_CYC] = sat_inc(cnt_q[C_CYC]);
      if (flush_in) cnt_d[C_FLUSH] = sat_inc(cnt_q[C_FLUSH]);
      if (stall_in) begin
        cnt_d[C_STALL] = sat_inc(cnt_q[C_STALL]);
        if (!prev_stall_q) cnt_d[C_EPI] = sat_inc(cnt_q[C_EPI]);
        cnt_d[C_RUN] = run_inc;
        // The longest run tracks the run as it grows, so it already
        // includes the cycle being counted now.
        if (run_inc > cnt_q[C_MAX]) cnt_d[C_MAX] = run_inc;
      end else begin
        cnt_d[C_RUN] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 6; i++) cnt_q[i] <= '0;
      prev_stall_q <= 1'b0;
    end else begin
      for (int i = 0; i < 6; i++) cnt_q[i] <= cnt_d[i];
      prev_stall_q <= prev_stall_d;
    end
  end

  // ------------------------------------------------------------------
  // Registered counter read-out
  // ------------------------------------------------------------------
  logic [CNT_W-1:0] rd_data_d, rd_data_q;

  always_comb begin
    rd_data_d = '0;
    case (rd_sel)
      3'd0:    rd_data_d = cnt_q[0];
      3'd1:    rd_data_d = cnt_q[1];
      3'd2:    rd_data_d = cnt_q[2];
      3'd3:    rd_data_d = cnt_q[3];
      3'd4:    rd_data_d = cnt_q[4];
      3'd5:    rd_data_d = cnt_q[5];
      default: rd_data_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rd_data_q <= '0;
    else        rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

  // ------------------------------------------------------------------
  // Flush trace (circular buffer, overwrite-oldest when full)
  // ------------------------------------------------------------------
  logic [PC_W-1:0] mem_q [TRACE_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;
  logic [PC_W-1:0] tr_data_q, tr_data_d;
  logic            tr_valid_q, tr_valid_d;
  logic            push, pop, full;

  assign full = (count_q == OCC_FULL);
  assign push = en && !clear && flush_in;
  assign pop  = tr_rd_en && !clear && (count_q != '0);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    tr_data_d  = tr_data_q;
    tr_valid_d = 1'b0;

    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (pop) begin
        tr_data_d  = mem_q[rd_ptr_q];
        tr_valid_d = 1'b1;
        rd_ptr_d   = rd_ptr_q + PTR_ONE;
      end
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;

      if (push && !pop) begin
        if (full) begin
          // Oldest entry is overwritten: drop it from the read side too.
          rd_ptr_d = rd_ptr_q + PTR_ONE;
          ovf_d    = 1'b1;
        end else begin
          count_d = count_q + OCC_ONE;
        end
      end else if (pop && !push) begin
        count_d = count_q - OCC_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      tr_data_q  <= '0;
      tr_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      tr_data_q  <= tr_data_d;
      tr_valid_q <= tr_valid_d;
    end
  end

  // Storage needs no reset: occupancy and pointers gate every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= pc_in;
  end

  assign tr_rd_data  = tr_data_q;
  assign tr_rd_valid = tr_valid_q;
  assign tr_count    = count_q;
  assign tr_overflow = ovf_q;

endmodule

// File: tb/tb_pipe_event_monitor.sv
// tb/tb_pipe_event_monitor.sv - directed self-checking bench for pipe_event_monitor
module tb_pipe_event_monitor;

  logic        clk;
  logic        reset;
  logic        en, freeze, clear;
  logic [31:0] pc_in;
  logic        stall_in, flush_in;
  logic [2:0]  rd_sel;
  logic        tr_rd_en;

  logic [31:0] rd_data_w;
  logic [31:0] tr_rd_data_w;
  logic        tr_rd_valid_w;
  logic [2:0]  tr_count_w;
  logic        tr_overflow_w;

  logic [3:0]  rd_data_n;
  logic [31:0] tr_rd_data_n;
  logic        tr_rd_valid_n;
  logic [2:0]  tr_count_n;
  logic        tr_overflow_n;

  int n_cmp = 0;
  int n_err = 0;

  pipe_event_monitor #(.CNT_W(32), .PC_W(32), .TRACE_DEPTH(4)) dut_w (
    .clk(clk), .reset(reset), .en(en), .freeze(freeze), .clear(clear),
    .pc_in(pc_in), .stall_in(stall_in), .flush_in(flush_in),
    .rd_sel(rd_sel), .rd_data(rd_data_w),
    .tr_rd_en(tr_rd_en), .tr_rd_data(tr_rd_data_w), .tr_rd_valid(tr_rd_valid_w),
    .tr_count(tr_count_w), .tr_overflow(tr_overflow_w)
  );

  pipe_event_monitor #(.CNT_W(4), .PC_W(32), .TRACE_DEPTH(4)) dut_n (
    .clk(clk), .reset(reset), .en(en), .freeze(freeze), .clear(clear),
    .pc_in(pc_in), .stall_in(stall_in), .flush_in(flush_in),
    .rd_sel(rd_sel), .rd_data(rd_data_n),
    .tr_rd_en(tr_rd_en), .tr_rd_data(tr_rd_data_n), .tr_rd_valid(tr_rd_valid_n),
    .tr_count(tr_count_n), .tr_overflow(tr_overflow_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then land on the falling edge for sampling/driving.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // Caller holds en=0 so the counters stay put during the read.
  task automatic read_cnt(input logic [2:0] sel, output logic [31:0] w, output logic [3:0] nv);
    rd_sel = sel;
    cyc(1);
    w  = rd_data_w;
    nv = rd_data_n;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
  endtask

  logic [31:0] rw;
  logic [3:0]  rn;
  logic [31:0] exp_c [6];
  logic        stall_pat [7];
  logic [31:0] pcs [5];

  initial begin
    reset = 1'b0; en = 1'b0; freeze = 1'b0; clear = 1'b0;
    pc_in = '0; stall_in = 1'b0; flush_in = 1'b0; rd_sel = '0; tr_rd_en = 1'b0;

    // Reset state
    @(negedge clk);
    check_eq("rst_rd_data", rd_data_w, 0);
    check_eq("rst_tr_count", tr_count_w, 0);
    check_eq("rst_tr_ovf", tr_overflow_w, 0);
    check_eq("rst_tr_valid", tr_rd_valid_w, 0);
    check_eq("rst_tr_data", tr_rd_data_w, 0);
    reset = 1'b1;
    cyc(1);

    // 10 idle counted cycles
    en = 1'b1;
    cyc(10);
    en = 1'b0;
    exp_c = '{32'd10, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    for (int i = 0; i < 6; i++) begin
      read_cnt(3'(i), rw, rn);
      check_eq($sformatf("idle_c%0d", i), rw, exp_c[i]);
    end
    read_cnt(3'd6, rw, rn);
    check_eq("sel6_zero", rw, 0);
    read_cnt(3'd7, rw, rn);
    check_eq("sel7_zero", rw, 0);

    // Stall pattern 1,1,1,0,1,1,0
    do_clear();
    stall_pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 7; i++) begin
      en = 1'b1;
      stall_in = stall_pat[i];
      cyc(1);
      if (i == 2) begin
        en = 1'b0;
        read_cnt(3'd5, rw, rn);
        check_eq("run_after_3", rw, 3);
      end
    end
    en = 1'b0; stall_in = 1'b0;
    exp_c = '{32'd7, 32'd5, 32'd0, 32'd2, 32'd3, 32'd0};
    for (int i = 0; i < 6; i++) begin
      read_cnt(3'(i), rw, rn);
      check_eq($sformatf("stall_c%0d", i), rw, exp_c[i]);
    end

    // Saturation on the 4-bit instance, then freeze with stalls
    do_clear();
    en = 1'b1;
    cyc(20);
    en = 1'b0;
    read_cnt(3'd0, rw, rn);
    check_eq("sat_c0_narrow", rn, 15);
    check_eq("c0_wide_20", rw, 20);
    en = 1'b1; freeze = 1'b1; stall_in = 1'b1;
    cyc(5);
    en = 1'b0; freeze = 1'b0; stall_in = 1'b0;
    read_cnt(3'd1, rw, rn);
    check_eq("freeze_c1_wide", rw, 0);
    check_eq("freeze_c1_narrow", rn, 0);
    read_cnt(3'd0, rw, rn);
    check_eq("freeze_c0_wide", rw, 20);
    check_eq("sat_c0_hold", rn, 15);

    // Trace overflow: 5 pushes into depth 4
    do_clear();
    pcs = '{32'h10, 32'h14, 32'h18, 32'h1C, 32'h20};
    en = 1'b1; flush_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pc_in = pcs[i];
      cyc(1);
    end
    en = 1'b0; flush_in = 1'b0;
    check_eq("ovf_count", tr_count_w, 4);
    check_eq("ovf_flag", tr_overflow_w, 1);
    tr_rd_en = 1'b1;
    for (int i = 1; i < 5; i++) begin
      cyc(1);
      check_eq($sformatf("pop%0d_valid", i), tr_rd_valid_w, 1);
      check_eq($sformatf("pop%0d_data", i), tr_rd_data_w, pcs[i]);
    end
    cyc(1);
    check_eq("pop_empty_valid", tr_rd_valid_w, 0);
    check_eq("pop_empty_count", tr_count_w, 0);
    tr_rd_en = 1'b0;

    // Full: simultaneous push and pop
    do_clear();
    en = 1'b1; flush_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pc_in = 32'h30 + 32'(4 * i);
      cyc(1);
    end
    check_eq("fill_count", tr_count_w, 4);
    check_eq("fill_ovf", tr_overflow_w, 0);
    pc_in = 32'h40; tr_rd_en = 1'b1;
    cyc(1);
    en = 1'b0; flush_in = 1'b0;
    check_eq("pp_valid", tr_rd_valid_w, 1);
    check_eq("pp_data", tr_rd_data_w, 32'h30);
    check_eq("pp_count", tr_count_w, 4);
    check_eq("pp_ovf", tr_overflow_w, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      check_eq($sformatf("pp_drain%0d", i), tr_rd_data_w, 32'h34 + 32'(4 * i));
    end
    tr_rd_en = 1'b0;
    cyc(1);
    check_eq("valid_drops", tr_rd_valid_w, 0);

    // Pop with push on empty: push lands, nothing returned
    en = 1'b1; flush_in = 1'b1; pc_in = 32'h50; tr_rd_en = 1'b1;
    cyc(1);
    en = 1'b0; flush_in = 1'b0;
    check_eq("pe_valid", tr_rd_valid_w, 0);
    check_eq("pe_count", tr_count_w, 1);
    cyc(1);
    check_eq("pe_pop_data", tr_rd_data_w, 32'h50);
    tr_rd_en = 1'b0;

    // Clear together with stall, flush and pop
    en = 1'b1; stall_in = 1'b1; flush_in = 1'b1; pc_in = 32'h70;
    cyc(5);
    check_eq("pre_clr_ovf", tr_overflow_w, 1);
    clear = 1'b1; tr_rd_en = 1'b1;
    cyc(1);
    clear = 1'b0; en = 1'b0; stall_in = 1'b0; flush_in = 1'b0; tr_rd_en = 1'b0;
    check_eq("clr_count", tr_count_w, 0);
    check_eq("clr_ovf", tr_overflow_w, 0);
    check_eq("clr_valid", tr_rd_valid_w, 0);
    for (int i = 0; i < 6; i++) begin
      read_cnt(3'(i), rw, rn);
      check_eq($sformatf("clr_c%0d", i), rw, 0);
    end

    // Asynchronous reset mid-run
    en = 1'b1; stall_in = 1'b1; flush_in = 1'b1; pc_in = 32'h60;
    tr_rd_en = 1'b1; rd_sel = 3'd0;
    cyc(3);
    check_eq("pre_rst_valid", tr_rd_valid_w, 1);
    check_eq("pre_rst_data", tr_rd_data_w, 32'h60);
    reset = 1'b0;
    #1;
    check_eq("arst_rd_data", rd_data_w, 0);
    check_eq("arst_tr_data", tr_rd_data_w, 0);
    check_eq("arst_tr_valid", tr_rd_valid_w, 0);
    check_eq("arst_tr_count", tr_count_w, 0);
    check_eq("arst_tr_ovf", tr_overflow_w, 0);
    en = 1'b0; stall_in = 1'b0; flush_in = 1'b0; tr_rd_en = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    read_cnt(3'd1, rw, rn);
    check_eq("arst_c1", rw, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_event_monitor.md
# pipe_event_monitor

Parametrised observation block for the pipelined core. It extends the bare `pc_out` / `stall_out` / `flush_out` exposure of the top level with saturating event counters, stall-run statistics and a circular trace buffer that records the PC on every flush. It sits beside the datapath in the top level and taps `pc_out`, `stall_out` and `flush_out` without feeding anything back into the pipeline.

## Interface

Parameters:
- `CNT_W`, 32: width of every counter; minimum 4.
- `PC_W`, 32: width of the traced PC.
- `TRACE_DEPTH`, 8: number of trace entries; power of two, minimum 2.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `en` in 1: monitor enable. When 0, all counters, run state and trace hold.
- `freeze` in 1: when 1, counters and run state hold. The trace keeps capturing.
- `clear` in 1: synchronous clear of counters, run state, trace and overflow.
- `pc_in` in PC_W: PC from the datapath.
- `stall_in` in 1: pipeline stall indication.
- `flush_in` in 1: pipeline flush indication.
- `rd_sel` in 3: counter select.
- `rd_data` out CNT_W: registered value of the selected counter.
- `tr_rd_en` in 1: pop request for the oldest trace entry.
- `tr_rd_data` out PC_W: popped PC.
- `tr_rd_valid` out 1: pulses for one cycle with `tr_rd_data`.
- `tr_count` out $clog2(TRACE_DEPTH)+1: current occupancy of the trace.
- `tr_overflow` out 1: sticky flag, set when an entry is overwritten.

## Operation

- Counting takes effect when `en`=1, `freeze`=0 and `clear`=0. Every counter saturates at all-ones and never wraps.
  - C0 cycles: +1 every counted cycle.
  - C1 stall cycles: +1 when `stall_in`=1.
  - C2 flush cycles: +1 when `flush_in`=1.
  - C3 stall episodes: +1 when `stall_in`=1 and the registered previous stall (`prev_stall`) is 0.
  - C4 max stall run: set to C5+1 when `stall_in`=1 and C5+1 > C4.
  - C5 current stall run: +1 when `stall_in`=1; set to 0 when `stall_in`=0.
- `prev_stall` loads `stall_in` only on counted cycles.
- Stall and flush in the same cycle: both are counted independently.
- `rd_sel` 0–5 selects C0–C5; values 6 and 7 read as 0.
- Trace push:
  - When `en`=1, `clear`=0 and `flush_in`=1, write `pc_in` at the write pointer. `freeze` is ignored.
  - When full and not popping in the same cycle, overwrite the oldest entry, advance the read pointer, keep `tr_count`=TRACE_DEPTH and set `tr_overflow`.
- Trace pop:
  - When `tr_rd_en`=1 and `tr_count`>0, output the oldest entry and advance the read pointer.
  - Pop on empty is ignored: `tr_rd_valid`=0 and no state changes.
  - Push and pop in the same cycle: the pop returns the pre-push oldest entry, `tr_count` is unchanged, and there is no overflow even when full.
  - A pop with push on empty returns nothing; the push still lands.
- Pointers wrap modulo TRACE_DEPTH.
- `clear` has the highest priority:
  - It zeroes all counters, `prev_stall`, pointers, `tr_count` and `tr_overflow`.
  - It suppresses the push and pop of that cycle.
  - `tr_rd_valid` is 0 in the following cycle.

## Timing

- Reset (`reset`=0, asynchronous) forces:
  - `rd_data`=0, `tr_rd_data`=0, `tr_rd_valid`=0, `tr_count`=0, `tr_overflow`=0;
  - all counters and pointers to 0.
- Reset asserted mid-operation discards all state immediately. Release is synchronised externally.
- Counter update: event at edge N is visible in the counter after edge N.
- `rd_data` shows the counter value after edge N registered at edge N+1: 1-cycle read latency from `rd_sel` or from a counter change.
- Trace: a pop request sampled at edge N gives `tr_rd_data` and `tr_rd_valid`=1 after edge N. `tr_rd_valid` is 0 otherwise.
- `tr_count` and `tr_overflow` are registered and update at the same edge as the push or pop.
- `freeze` and `en` act in the cycle they are sampled; there is no pipelining of control.

## Test plan

- Reset, then 10 cycles with `en`=1, `stall_in`=0 and `flush_in`=0. Require C0=10 and C1–C5=0. `rd_sel`=6 must give `rd_data`=0.
- Stall pattern 1,1,1,0,1,1,0 over 7 counted cycles. Require C1=5, C3=2, C4=3, C5=0. At the cycle after the third stall, C5=3.
- With `CNT_W`=4, run 20 counted cycles. Require C0=15 and it holds. `freeze`=1 for 5 cycles with stalls must leave C1 unchanged.
- With `TRACE_DEPTH`=4, push flushes with PCs 0x10, 0x14, 0x18, 0x1C, 0x20. Require `tr_count`=4 and `tr_overflow`=1. Pops must return 0x14, 0x18, 0x1C, 0x20 with `tr_rd_valid` pulses. A fifth pop gives `tr_rd_valid`=0.
- When full, a simultaneous flush (PC 0x40) and pop returns the oldest entry. Require `tr_count`=4 and `tr_overflow` unchanged.
- Assert `clear` in the same cycle as a stall and a flush. Next cycle require all counters=0, `tr_count`=0 and `tr_overflow`=0. Also drop `reset` mid-run and check that every output is 0 before the next edge.
